// File: rtl/pin_verification.sv
// Session PIN checker: latches the stored BCD PIN when a session starts, buffers keypad
// digits, compares them on Enter, and then grants access, retains the card, or ejects.
module pin_verification #(
  parameter int P_WIDTH     = 16,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  localparam int NUM_DIGITS = P_WIDTH / 4,
  localparam int AW         = ($clog2(MAX_TRIES + 1) < 2) ? 2 : $clog2(MAX_TRIES + 1),
  localparam int CW         = $clog2(NUM_DIGITS + 1),
  localparam int TW         = $clog2(TIMEOUT_CYC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pass_en,
  input  logic [P_WIDTH-1:0] password,
  input  logic [3:0]         digit_in,
  input  logic               digit_valid,
  input  logic               enter,
  input  logic               clear,
  input  logic               cancel,
  input  logic               session_end,
  output logic               pin_ok,
  output logic               pin_wrong,
  output logic               card_retained,
  output logic               eject,
  output logic               timeout,
  output logic [AW-1:0]      attempts_left,
  output logic [CW-1:0]      digit_count
);

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, GRANTED, RETAIN, EJECT} state_t;

  state_t             state;
  logic               pass_q;
  logic [P_WIDTH-1:0] buffer;
  logic [P_WIDTH-1:0] pin;
  logic [TW-1:0]      timer;

  logic buf_full;
  logic digit_ok;

  assign buf_full = (digit_count == CW'(NUM_DIGITS));
  assign digit_ok = digit_valid && (digit_in <= 4'd9) && !buf_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      pass_q        <= 1'b0;
      buffer        <= '0;
      pin           <= '0;
      timer         <= '0;
      pin_ok        <= 1'b0;
      pin_wrong     <= 1'b0;
      card_retained <= 1'b0;
      eject         <= 1'b0;
      timeout       <= 1'b0;
      attempts_left <= '0;
      digit_count   <= '0;
    end else begin
      // NOTE: pulse outputs default low every cycle and only the branch that fires raises
      // them; with non-blocking assignments the later override wins without races.
      pin_wrong <= 1'b0;
      eject     <= 1'b0;
      timeout   <= 1'b0;
      pass_q    <= pass_en;

      case (state)
        IDLE: begin
          if (pass_en && !pass_q) begin
            pin           <= password;
            attempts_left <= AW'(MAX_TRIES);
            buffer        <= '0;
            digit_count   <= '0;
            timer         <= '0;
            state         <= ENTRY;
          end
        end

        ENTRY: begin
          if (cancel) begin
            eject <= 1'b1;
            state <= EJECT;
          end else if (clear) begin
            buffer      <= '0;
            digit_count <= '0;
            timer       <= '0;
          end else if (enter && buf_full) begin
            timer <= '0;
            state <= CHECK;
          end else if (digit_ok) begin
            buffer      <= (buffer << 4) | P_WIDTH'(digit_in);
            digit_count <= digit_count + 1'b1;
            timer       <= '0;
          end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
            eject   <= 1'b1;
            timeout <= 1'b1;
            state   <= EJECT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        CHECK: begin
          if (buffer == pin) begin
            pin_ok <= 1'b1;
            state  <= GRANTED;
          end else if (attempts_left > AW'(1)) begin
            attempts_left <= attempts_left - 1'b1;
            buffer        <= '0;
            digit_count   <= '0;
            timer         <= '0;
            pin_wrong     <= 1'b1;
            state         <= ENTRY;
          end else begin
            attempts_left <= '0;
            card_retained <= 1'b1;
            state         <= RETAIN;
          end
        end

        GRANTED: begin
          if (session_end) begin
            pin_ok      <= 1'b0;
            buffer      <= '0;
            pin         <= '0;
            digit_count <= '0;
            state       <= IDLE;
          end
        end

        RETAIN: begin
          if (session_end) begin
            card_retained <= 1'b0;
            buffer        <= '0;
            pin           <= '0;
            digit_count   <= '0;
            state         <= IDLE;
          end
        end

        EJECT: begin
          buffer      <= '0;
          pin         <= '0;
          digit_count <= '0;
          timer       <= '0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pin_verification.sv
// Bench for pin_verification: per-cycle vector table fed through a scoreboard queue,
// plus hand-written asynchronous-reset sequences.
module tb_pin_verification;

  localparam int TO = 20;
  localparam int PE = 1, DV = 2, EN = 4, CL = 8, CA = 16, SE = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        pass_en, digit_valid, enter, clear, cancel, session_end;
  logic [15:0] password;
  logic [3:0]  digit_in;
  logic        pin_ok, pin_wrong, card_retained, eject, timeout;
  logic [1:0]  attempts_left;
  logic [2:0]  digit_count;

  always #5 clk = ~clk;

  pin_verification #(.P_WIDTH(16), .MAX_TRIES(3), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .pass_en(pass_en), .password(password),
    .digit_in(digit_in), .digit_valid(digit_valid), .enter(enter), .clear(clear),
    .cancel(cancel), .session_end(session_end), .pin_ok(pin_ok), .pin_wrong(pin_wrong),
    .card_retained(card_retained), .eject(eject), .timeout(timeout),
    .attempts_left(attempts_left), .digit_count(digit_count)
  );

  typedef struct packed {
    logic       ok, wr, rt, ej, to;
    logic [1:0] att;
    logic [2:0] cnt;
  } obs_t;

  typedef struct {
    string       name;
    logic        pe, dv, en, cl, ca, se;
    logic [15:0] pw;
    logic [3:0]  dig;
    obs_t        exp;
  } vec_t;

  vec_t        tbl[$];
  obs_t        sb_q[$];
  string       sb_n[$];
  logic [15:0] tbl_pw;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (ok,wr,rt,ej,to,att[2],cnt[3])", name, act, exp);
    end
  endtask

  function automatic obs_t o(input bit ok, input bit wr, input bit rt, input bit ej,
                             input bit to, input int att, input int cnt);
    obs_t r;
    r.ok = ok; r.wr = wr; r.rt = rt; r.ej = ej; r.to = to;
    r.att = 2'(att);
    r.cnt = 3'(cnt);
    return r;
  endfunction

  function automatic obs_t sample();
    return {pin_ok, pin_wrong, card_retained, eject, timeout, attempts_left, digit_count};
  endfunction

  task automatic add(input string n, input int ctl, input logic [3:0] dig, input obs_t e);
    vec_t t;
    t.name = n;
    t.pe = ctl[0]; t.dv = ctl[1]; t.en = ctl[2]; t.cl = ctl[3]; t.ca = ctl[4]; t.se = ctl[5];
    t.pw = tbl_pw;
    t.dig = dig;
    t.exp = e;
    tbl.push_back(t);
  endtask

  task automatic dig4(input string n, input logic [15:0] d, input int att);
    for (int i = 0; i < 4; i++) add(n, DV, d[15-4*i -: 4], o(0, 0, 0, 0, 0, att, i + 1));
  endtask

  task automatic idle_inputs();
    pass_en = 0; password = '0; digit_in = '0; digit_valid = 0;
    enter = 0; clear = 0; cancel = 0; session_end = 0;
  endtask

  task automatic step(input vec_t t);
    @(negedge clk);
    pass_en = t.pe; password = t.pw; digit_in = t.dig; digit_valid = t.dv;
    enter = t.en; clear = t.cl; cancel = t.ca; session_end = t.se;
    sb_q.push_back(t.exp);
    sb_n.push_back(t.name);
    @(posedge clk);
    #1;
    check(sb_n.pop_front(), 16'(sample()), 16'(sb_q.pop_front()));
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) step(tbl[i]);
    tbl.delete();
  endtask

  task automatic pulse_reset(input string n);
    @(negedge clk);
    idle_inputs();
    #2 rst = 0;
    #1 check(n, 16'(sample()), 16'(o(0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    #3 check("reset state", 16'(sample()), 16'(o(0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    rst = 1;

    // Correct PIN first try, then session_end
    tbl_pw = 16'h3370;
    add("t1 start", PE, 0, o(0, 0, 0, 0, 0, 3, 0));
    dig4("t1 digit", 16'h3370, 3);
    add("t1 enter", EN, 0, o(0, 0, 0, 0, 0, 3, 4));
    add("t1 granted", 0, 0, o(1, 0, 0, 0, 0, 3, 4));
    add("t1 granted hold", 0, 0, o(1, 0, 0, 0, 0, 3, 4));
    add("t1 session_end", SE, 0, o(0, 0, 0, 0, 0, 3, 0));
    add("t1 idle", 0, 0, o(0, 0, 0, 0, 0, 3, 0));

    // Two wrong PINs then correct
    tbl_pw = 16'h3506;
    add("t2 start", PE, 0, o(0, 0, 0, 0, 0, 3, 0));
    dig4("t2 wrong1 digit", 16'h1111, 3);
    add("t2 enter1", EN, 0, o(0, 0, 0, 0, 0, 3, 4));
    add("t2 pin_wrong1", 0, 0, o(0, 1, 0, 0, 0, 2, 0));
    dig4("t2 wrong2 digit", 16'h1111, 2);
    add("t2 enter2", EN, 0, o(0, 0, 0, 0, 0, 2, 4));
    add("t2 pin_wrong2", 0, 0, o(0, 1, 0, 0, 0, 1, 0));
    dig4("t2 right digit", 16'h3506, 1);
    add("t2 enter3", EN, 0, o(0, 0, 0, 0, 0, 1, 4));
    add("t2 granted", 0, 0, o(1, 0, 0, 0, 0, 1, 4));
    add("t2 session_end", SE, 0, o(0, 0, 0, 0, 0, 1, 0));

    // Three wrong PINs -> retention
    tbl_pw = 16'h1234;
    add("t3 start", PE, 0, o(0, 0, 0, 0, 0, 3, 0));
    dig4("t3 wrong1 digit", 16'h0000, 3);
    add("t3 enter1", EN, 0, o(0, 0, 0, 0, 0, 3, 4));
    add("t3 pin_wrong1", 0, 0, o(0, 1, 0, 0, 0, 2, 0));
    dig4("t3 wrong2 digit", 16'h0000, 2);
    add("t3 enter2", EN, 0, o(0, 0, 0, 0, 0, 2, 4));
    add("t3 pin_wrong2", 0, 0, o(0, 1, 0, 0, 0, 1, 0));
    dig4("t3 wrong3 digit", 16'h0000, 1);
    add("t3 enter3", EN, 0, o(0, 0, 0, 0, 0, 1, 4));
    add("t3 retained", 0, 0, o(0, 0, 1, 0, 0, 0, 4));
    add("t3 digit ignored", DV, 5, o(0, 0, 1, 0, 0, 0, 4));
    add("t3 cancel ignored", CA, 0, o(0, 0, 1, 0, 0, 0, 4));
    add("t3 clear ignored", CL, 0, o(0, 0, 1, 0, 0, 0, 4));
    add("t3 enter ignored", EN, 0, o(0, 0, 1, 0, 0, 0, 4));
    add("t3 session_end", SE, 0, o(0, 0, 0, 0, 0, 0, 0));
    add("t3 idle", 0, 0, o(0, 0, 0, 0, 0, 0, 0));

    // Entry edge cases
    tbl_pw = 16'h2468;
    add("t4 start", PE, 0, o(0, 0, 0, 0, 0, 3, 0));
    add("t4 d2", DV, 2, o(0, 0, 0, 0, 0, 3, 1));
    add("t4 d4", DV, 4, o(0, 0, 0, 0, 0, 3, 2));
    add("t4 d6", DV, 6, o(0, 0, 0, 0, 0, 3, 3));
    add("t4 short enter", EN, 0, o(0, 0, 0, 0, 0, 3, 3));
    add("t4 no check", 0, 0, o(0, 0, 0, 0, 0, 3, 3));
    add("t4 digit A ignored", DV, 4'hA, o(0, 0, 0, 0, 0, 3, 3));
    add("t4 d8", DV, 8, o(0, 0, 0, 0, 0, 3, 4));
    add("t4 clear", CL, 0, o(0, 0, 0, 0, 0, 3, 0));
    dig4("t4 refill", 16'h2468, 3);
    add("t4 clear+enter", CL | EN, 0, o(0, 0, 0, 0, 0, 3, 0));
    add("t4 clear won", 0, 0, o(0, 0, 0, 0, 0, 3, 0));
    dig4("t4 refill2", 16'h2468, 3);
    add("t4 fifth digit ignored", DV, 9, o(0, 0, 0, 0, 0, 3, 4));
    add("t4 session_end in entry", SE, 0, o(0, 0, 0, 0, 0, 3, 4));
    add("t4 pass_en in entry", PE, 0, o(0, 0, 0, 0, 0, 3, 4));
    add("t4 enter", EN, 0, o(0, 0, 0, 0, 0, 3, 4));
    add("t4 granted", 0, 0, o(1, 0, 0, 0, 0, 3, 4));
    add("t4 session_end", SE, 0, o(0, 0, 0, 0, 0, 3, 0));

    // Cancel ejects without timeout
    tbl_pw = 16'h1111;
    add("cancel start", PE, 0, o(0, 0, 0, 0, 0, 3, 0));
    add("cancel d1", DV, 1, o(0, 0, 0, 0, 0, 3, 1));
    add("cancel eject", CA, 0, o(0, 0, 0, 1, 0, 3, 1));
    add("cancel back idle", 0, 0, o(0, 0, 0, 0, 0, 3, 0));

    // Inactivity timeout with pass_en held high throughout
    add("t5 start", PE, 0, o(0, 0, 0, 0, 0, 3, 0));
    add("t5 d1", PE | DV, 1, o(0, 0, 0, 0, 0, 3, 1));
    for (int i = 1; i < TO; i++) add("t5 waiting", PE, 0, o(0, 0, 0, 0, 0, 3, 1));
    add("t5 timeout eject", PE, 0, o(0, 0, 0, 1, 1, 3, 1));
    add("t5 idle after eject", PE, 0, o(0, 0, 0, 0, 0, 3, 0));
    add("t5 held pass_en no restart", PE | DV, 5, o(0, 0, 0, 0, 0, 3, 0));
    add("t5 release pass_en", 0, 0, o(0, 0, 0, 0, 0, 3, 0));
    run_tbl();

    // Reset mid-ENTRY with two digits buffered
    tbl_pw = 16'h4321;
    add("t6 start", PE, 0, o(0, 0, 0, 0, 0, 3, 0));
    add("t6 d4", DV, 4, o(0, 0, 0, 0, 0, 3, 1));
    add("t6 d3", DV, 3, o(0, 0, 0, 0, 0, 3, 2));
    run_tbl();
    pulse_reset("t6 reset in entry");
    add("t6 idle after reset", DV, 4, o(0, 0, 0, 0, 0, 0, 0));
    add("t6 restart", PE, 0, o(0, 0, 0, 0, 0, 3, 0));
    dig4("t6 digit", 16'h4321, 3);
    add("t6 enter", EN, 0, o(0, 0, 0, 0, 0, 3, 4));
    add("t6 granted", 0, 0, o(1, 0, 0, 0, 0, 3, 4));
    run_tbl();
    pulse_reset("t6 reset in granted");
    add("t6 idle after reset2", EN, 0, o(0, 0, 0, 0, 0, 0, 0));
    run_tbl();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
